hilo_issue: RTL and testbench

//  Pipeline-side initiator for the div_mul unit. Owns the architectural HI/LO registers.

---
 rtl/hilo_issue.sv | 208 ++++++++++++++++++++
 tb/tb_hilo_issue.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_issue.sv
// ============================================================================
// hilo_issue
// ----------------------------------------------------------------------------
// Pipeline-side initiator for the multi-cycle div_mul unit. Owns the
// architectural HI/LO registers. It does the following:
//   * captures MUL/DIV/MADD/MSUB from EX
//   * launches div_mul with registered operands that stay stable until the
//     result is written back
//   * commits the result to HI/LO on dm_write
//   * serves MTHI/MTLO/MFHI/MFLO
//   * stalls EX when a HI/LO op meets an operation that is still in flight
//
// Optional feature (macro HILO_FORWARD_EN):
//   When defined, an MF in the dm_write cycle reads dm_hi_res/dm_lo_res
//   directly and does not stall. MTHI/MTLO in that cycle still stall once.
//   When undefined, an MF in the dm_write cycle stalls one cycle and then
//   reads the committed HI/LO.
//
// Ports
//   clk             clock
//   reset           asynchronous, active-low reset
//   flush           pipeline flush: kills the in-flight op and the EX op
//   ex_valid        EX slot holds a HI/LO op
//   ex_op[2:0]      0 NONE, 1 MUL, 2 DIV, 3 MADD, 4 MSUB, 5 MTHI, 6 MTLO, 7 MF
//   ex_sign         signed operation
//   ex_a, ex_b      rs / rt operands
//   ex_stall        hold EX this cycle (op not accepted)
//   hi_out, lo_out  HI/LO read value for MF
//   dm_mul, dm_div  registered div_mul requests
//   dm_add, dm_sub  registered MADD / MSUB selects
//   dm_sign         registered signedness to div_mul
//   dm_a, dm_b      registered operands to div_mul
//   dm_hi, dm_lo    current HI/LO, used as the accumulator input of div_mul
//   dm_clear        one-cycle abort pulse to div_mul
//   dm_hold_result  tied low
//   dm_hi_res,
//   dm_lo_res       div_mul result
//   dm_write        div_mul result-valid (write_hi_lo)
// ============================================================================
module hilo_issue #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         ex_valid,
    input  logic [2:0]   ex_op,
    input  logic         ex_sign,
    input  logic [N-1:0] ex_a,
    input  logic [N-1:0] ex_b,
    output logic         ex_stall,
    output logic [N-1:0] hi_out,
    output logic [N-1:0] lo_out,
    output logic         dm_mul,
    output logic         dm_div,
    output logic         dm_add,
    output logic         dm_sub,
    output logic         dm_sign,
    output logic [N-1:0] dm_a,
    output logic [N-1:0] dm_b,
    output logic [N-1:0] dm_hi,
    output logic [N-1:0] dm_lo,
    output logic         dm_clear,
    output logic         dm_hold_result,
    input  logic [N-1:0] dm_hi_res,
    input  logic [N-1:0] dm_lo_res,
    input  logic         dm_write
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MADD = 3'd3;
    localparam logic [2:0] OP_MSUB = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;
    localparam logic [2:0] OP_MF   = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state_reg;
    logic [N-1:0] hi_reg;
    logic [N-1:0] lo_reg;
    logic         mul_reg;
    logic         div_reg;
    logic         add_reg;
    logic         sub_reg;
    logic         sign_reg;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         clear_reg;

    // ------------------------------------------------------------------
    // EX-side decode. A flushed EX op is never accepted and never stalls.
    // ------------------------------------------------------------------
    logic op_live;
    logic op_is_hilo;
    logic op_is_arith;
    logic busy;
    logic fwd_hit;

    assign op_live     = ex_valid & ~flush;
    assign op_is_hilo  = (ex_op != OP_NONE);
    assign op_is_arith = (ex_op == OP_MUL) || (ex_op == OP_DIV) ||
                         (ex_op == OP_MADD) || (ex_op == OP_MSUB);
    assign busy        = (state_reg == BUSY);

`ifdef HILO_FORWARD_EN
    // The result arriving this cycle is the value HI/LO hold after the edge,
    // so an MF can take it directly instead of waiting for the commit.
    assign fwd_hit = busy & dm_write & op_live & (ex_op == OP_MF);
`else
    assign fwd_hit = 1'b0;
`endif

    // The stall must act in the same cycle as the EX op, so it is decoded
    // combinationally from the registered state rather than registered.
    assign ex_stall = op_live & op_is_hilo & busy & ~fwd_hit;

    assign hi_out = fwd_hit ? dm_hi_res : hi_reg;
    assign lo_out = fwd_hit ? dm_lo_res : lo_reg;

    // div_mul accumulates from the live HI/LO. Nothing can write HI/LO while
    // BUSY except the commit itself, so these are stable during an operation.
    assign dm_hi          = hi_reg;
    assign dm_lo          = lo_reg;
    assign dm_mul         = mul_reg;
    assign dm_div         = div_reg;
    assign dm_add         = add_reg;
    assign dm_sub         = sub_reg;
    assign dm_sign        = sign_reg;
    assign dm_a           = a_reg;
    assign dm_b           = b_reg;
    assign dm_clear       = clear_reg;
    assign dm_hold_result = 1'b0;

    // ------------------------------------------------------------------
    // Issue FSM. Flush has priority over acceptance and over commit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            mul_reg   <= 1'b0;
            div_reg   <= 1'b0;
            add_reg   <= 1'b0;
            sub_reg   <= 1'b0;
            sign_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            clear_reg <= 1'b0;
        end else begin
            clear_reg <= 1'b0;
            if (flush) begin
                if (state_reg == BUSY) begin
                    // Abort div_mul. A result arriving in this same cycle is
                    // dropped, so HI/LO keep their pre-operation values.
                    clear_reg <= 1'b1;
                    mul_reg   <= 1'b0;
                    div_reg   <= 1'b0;
                    add_reg   <= 1'b0;
                    sub_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ex_valid && op_is_arith) begin
                            a_reg     <= ex_a;
                            b_reg     <= ex_b;
                            sign_reg  <= ex_sign;
                            mul_reg   <= (ex_op != OP_DIV);
                            div_reg   <= (ex_op == OP_DIV);
                            add_reg   <= (ex_op == OP_MADD);
                            sub_reg   <= (ex_op == OP_MSUB);
                            state_reg <= BUSY;
                        end else if (ex_valid && (ex_op == OP_MTHI)) begin
                            hi_reg <= ex_a;
                        end else if (ex_valid && (ex_op == OP_MTLO)) begin
                            lo_reg <= ex_a;
                        end
                    end
                    BUSY: begin
                        // Requests stay asserted until the result arrives.
                        // Dropping them at commit gives div_mul at least one
                        // low cycle to return to its wait state, so it does
                        // not relaunch on a stale request.
                        if (dm_write) begin
                            hi_reg    <= dm_hi_res;
                            lo_reg    <= dm_lo_res;
                            mul_reg   <= 1'b0;
                            div_reg   <= 1'b0;
                            add_reg   <= 1'b0;
                            sub_reg   <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_issue.sv
// ============================================================================
// tb_hilo_issue
// Directed bench for hilo_issue.
//
// The bench contains a small behavioural stand-in for div_mul. It has a fixed
// latency: MUL-type operations take 5 cycles and DIV takes 10 cycles. The
// stand-in honours dm_clear and waits for the request to drop before it
// accepts a new operation.
//
// Expected HI/LO values are constants. They are pushed to a queue when the
// operation is issued, and popped when the commit is observed.
// ============================================================================
module tb_hilo_issue;

    localparam int N = 32;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MADD = 3'd3;
    localparam logic [2:0] OP_MSUB = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;
    localparam logic [2:0] OP_MF   = 3'd7;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         ex_valid;
    logic [2:0]   ex_op;
    logic         ex_sign;
    logic [N-1:0] ex_a;
    logic [N-1:0] ex_b;
    logic         ex_stall;
    logic [N-1:0] hi_out;
    logic [N-1:0] lo_out;
    logic         dm_mul;
    logic         dm_div;
    logic         dm_add;
    logic         dm_sub;
    logic         dm_sign;
    logic [N-1:0] dm_a;
    logic [N-1:0] dm_b;
    logic [N-1:0] dm_hi;
    logic [N-1:0] dm_lo;
    logic         dm_clear;
    logic         dm_hold_result;
    logic [N-1:0] dm_hi_res;
    logic [N-1:0] dm_lo_res;
    logic         dm_write;

    hilo_issue #(.N(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_op          (ex_op),
        .ex_sign        (ex_sign),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_stall       (ex_stall),
        .hi_out         (hi_out),
        .lo_out         (lo_out),
        .dm_mul         (dm_mul),
        .dm_div         (dm_div),
        .dm_add         (dm_add),
        .dm_sub         (dm_sub),
        .dm_sign        (dm_sign),
        .dm_a           (dm_a),
        .dm_b           (dm_b),
        .dm_hi          (dm_hi),
        .dm_lo          (dm_lo),
        .dm_clear       (dm_clear),
        .dm_hold_result (dm_hold_result),
        .dm_hi_res      (dm_hi_res),
        .dm_lo_res      (dm_lo_res),
        .dm_write       (dm_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural div_mul stand-in
    // ------------------------------------------------------------------
    function automatic logic [63:0] dm_calc(
        input logic        is_div,
        input logic        sgn,
        input logic        add,
        input logic        sub,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        logic [63:0] p;
        int          sa;
        int          sb;
        int          q;
        int          r;
        if (is_div) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (sgn) begin
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
        end
        if (sgn) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else     p = {32'd0, a} * {32'd0, b};
        if (add) return {hi, lo} + p;
        if (sub) return {hi, lo} - p;
        return p;
    endfunction

    int         m_state;
    logic [3:0] m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state   <= 0;
            m_cnt     <= 4'd0;
            dm_write  <= 1'b0;
            dm_hi_res <= '0;
            dm_lo_res <= '0;
        end else if (dm_clear) begin
            m_state  <= 0;
            dm_write <= 1'b0;
        end else begin
            case (m_state)
                0: if (dm_mul || dm_div) begin
                    m_cnt   <= dm_div ? 4'd10 : 4'd5;
                    m_state <= 1;
                end
                1: if (m_cnt == 4'd1) begin
                    dm_write <= 1'b1;
                    {dm_hi_res, dm_lo_res} <= dm_calc(dm_div, dm_sign, dm_add, dm_sub,
                                                      dm_a, dm_b, dm_hi, dm_lo);
                    m_state <= 2;
                end else begin
                    m_cnt <= m_cnt - 4'd1;
                end
                default: begin
                    dm_write <= 1'b0;
                    if (!(dm_mul || dm_div)) m_state <= 0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.tag = tag;
        e.hi  = hi;
        e.lo  = lo;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_sign  = sgn;
        ex_a     = a;
        ex_b     = b;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_op    = OP_NONE;
        ex_sign  = 1'b0;
        ex_a     = '0;
        ex_b     = '0;
    endtask

    // Wait for the commit cycle. In that cycle the request must still be
    // held. On the following cycle the request must be low and HI/LO must
    // match the scoreboard.
    task automatic wait_commit(input bit is_div);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (dm_write) begin
                seen = 1'b1;
                break;
            end
        end
        check("commit_seen", seen, 1'b1);
        check("req_held_at_write", is_div ? dm_div : dm_mul, 1'b1);
        @(negedge clk);
        #1;
        check("req_gap", {dm_mul, dm_div}, 2'b00);
        e = sb.pop_front();
        check({e.tag, "_hi"}, hi_out, e.hi);
        check({e.tag, "_lo"}, lo_out, e.lo);
        $display("txn %s: hi=%h lo=%h", e.tag, hi_out, lo_out);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        bit released;
        bit w_at_release;
        int writes;
        exp_t e;

        reset = 1'b0;
        flush = 1'b0;
        idle_ex();
        #1;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_req", {dm_mul, dm_div, dm_add, dm_sub, dm_sign}, 5'd0);
        check("rst_ops", {dm_a, dm_b}, 64'd0);
        check("rst_ctl", {dm_clear, ex_stall, dm_hold_result}, 3'd0);
        $display("txn RESET: hi=%h lo=%h", hi_out, lo_out);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Unsigned MUL 7*6
        @(negedge clk);
        drive(OP_MUL, 1'b0, 32'd7, 32'd6);
        #1;
        check("mul_accept_stall", ex_stall, 1'b0);
        push_exp("MUL7x6", 32'd0, 32'd42);
        @(negedge clk);
        idle_ex();
        #1;
        check("mul_req", {dm_mul, dm_div, dm_add, dm_sub, dm_sign}, 5'b10000);
        check("mul_ops", {dm_a, dm_b}, {32'd7, 32'd6});
        wait_commit(1'b0);

        // Signed DIV -7/2
        @(negedge clk);
        drive(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        push_exp("DIVm7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk);
        idle_ex();
        #1;
        check("div_req", {dm_mul, dm_div, dm_sign}, 3'b011);
        wait_commit(1'b1);

        // MTHI 0, MTLO all-ones, read back, then MADD 1*1
        @(negedge clk);
        drive(OP_MTHI, 1'b0, 32'd0, 32'd0);
        #1;
        check("mthi_stall", ex_stall, 1'b0);
        @(negedge clk);
        drive(OP_MTLO, 1'b0, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk);
        drive(OP_MF, 1'b0, 32'd0, 32'd0);
        #1;
        check("mt_hi", hi_out, 32'd0);
        check("mt_lo", lo_out, 32'hFFFF_FFFF);
        $display("txn MTHI/MTLO: hi=%h lo=%h", hi_out, lo_out);
        @(negedge clk);
        drive(OP_MADD, 1'b0, 32'd1, 32'd1);
        push_exp("MADD1x1", 32'd1, 32'd0);
        @(negedge clk);
        idle_ex();
        #1;
        check("madd_req", {dm_mul, dm_div, dm_add, dm_sub}, 4'b1010);
        check("madd_acc", {dm_hi, dm_lo}, {32'd0, 32'hFFFF_FFFF});
        wait_commit(1'b0);

        // MF issued while MUL 3*5 is in flight
        @(negedge clk);
        drive(OP_MUL, 1'b0, 32'd3, 32'd5);
        push_exp("MF_after_MUL3x5", 32'd0, 32'd15);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        drive(OP_MF, 1'b0, 32'd0, 32'd0);
        #1;
        check("mf_stall_busy", ex_stall, 1'b1);
        released     = 1'b0;
        w_at_release = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (!ex_stall) begin
                released     = 1'b1;
                w_at_release = dm_write;
                break;
            end
        end
        check("mf_released", released, 1'b1);
`ifdef HILO_FORWARD_EN
        check("mf_release_cycle", w_at_release, 1'b1);
`else
        check("mf_release_cycle", w_at_release, 1'b0);
`endif
        e = sb.pop_front();
        check({e.tag, "_hi"}, hi_out, e.hi);
        check({e.tag, "_lo"}, lo_out, e.lo);
        $display("txn %s: hi=%h lo=%h", e.tag, hi_out, lo_out);
        @(negedge clk);
        idle_ex();
        @(negedge clk);

        // Flush 5 cycles into DIV 100/7
        @(negedge clk);
        drive(OP_DIV, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        drive(OP_NONE, 1'b0, 32'd0, 32'd0);
        #1;
        check("nonhilo_no_stall", ex_stall, 1'b0);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        @(negedge clk);
        drive(OP_MUL, 1'b0, 32'd2, 32'd2);
        flush = 1'b1;
        #1;
        check("flush_ex_stall", ex_stall, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        idle_ex();
        #1;
        check("flush_clear", dm_clear, 1'b1);
        check("flush_req_drop", {dm_mul, dm_div}, 2'b00);
        @(negedge clk);
        #1;
        check("flush_clear_once", dm_clear, 1'b0);
        writes = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            #1;
            if (dm_write) writes++;
        end
        check("flush_no_write", writes, 0);
        check("flush_keep_hi", hi_out, 32'd0);
        check("flush_keep_lo", lo_out, 32'd15);
        $display("txn FLUSH DIV100/7: hi=%h lo=%h", hi_out, lo_out);

        @(negedge clk);
        drive(OP_MUL, 1'b0, 32'd2, 32'd2);
        push_exp("MUL2x2", 32'd0, 32'd4);
        @(negedge clk);
        idle_ex();
        wait_commit(1'b0);

        // Async reset in the middle of a signed MUL
        @(negedge clk);
        drive(OP_MUL, 1'b1, 32'd9, 32'd9);
        @(negedge clk);
        idle_ex();
        #1;
        check("pre_reset_req", dm_mul, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_req", {dm_mul, dm_div, dm_add, dm_sub, dm_sign}, 5'd0);
        check("async_rst_ops", {dm_a, dm_b}, 64'd0);
        check("async_rst_hilo", {hi_out, lo_out}, 64'd0);
        check("async_rst_ctl", {dm_clear, ex_stall}, 2'd0);
        $display("txn RESET mid-MUL: hi=%h lo=%h", hi_out, lo_out);
        @(negedge clk);
        reset = 1'b1;

        // Signed MUL -2*3 after reset
        @(negedge clk);
        drive(OP_MUL, 1'b1, 32'hFFFF_FFFE, 32'd3);
        push_exp("MULm2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        @(negedge clk);
        idle_ex();
        wait_commit(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
